tx_core: RTL

- UART-style serial transmitter; the transmit end of the 11-bit frame that the team's receive core consumes.
- Frame order: start bit, 8 data bits LSB first, parity slot, stop bit(s).
- Contains its own baud divider, so no external bps_clk strobe is needed.
- Sits between the command/response logic (byte source) and the TXD pad.

---
 rtl/tx_core.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tx_core.sv
// UART-style serial transmitter: start bit, 8 data bits LSB first, parity slot, STOP_BITS stop bits.
// Build option: define TX_PARITY_EN to send computed parity in the parity slot (otherwise it is a constant mark).
module tx_core #(
  parameter int CLK_DIV    = 434,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       txd
);

  localparam int   CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             stop_idx_q, stop_idx_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic baud_tick;
  logic accept;
  logic parity_bit;

  assign baud_tick = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign accept    = (state_q == IDLE) && tx_valid && ready_q && tx_en;

`ifdef TX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic parity_q;

  // Parity is captured with the byte, since the shift register is consumed by the time the slot arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= (^tx_data) ^ ODD;
    end
  end

  assign parity_bit = parity_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
  assign parity_bit        = 1'b1;
`endif

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    stop_idx_d = stop_idx_q;
    txd_d      = txd_q;
    ready_d    = ready_q;
    done_d     = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = baud_tick ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        txd_d   = 1'b1;
        ready_d = 1'b1;
        if (accept) begin
          shift_d   = tx_data;
          bit_idx_d = '0;
          cnt_d     = '0;
          txd_d     = 1'b0;
          ready_d   = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (baud_tick) begin
          txd_d   = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == 3'd7) begin
            txd_d   = parity_bit;
            state_d = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          txd_d      = 1'b1;
          stop_idx_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_idx_q == LAST_STOP) begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign tx_ready = ready_q;
  assign tx_done  = done_q;
  assign txd      = txd_q;

endmodule
